hit_map_ctrl: RTL and testbench
===============================

Name: hit_map_ctrl

Overview:
Owns the hit/miss state of both 10x10 boards (host, guest) and schedules all access to it.
- Serves the renderer (draw_hit cell indices) every pixel through a fixed-latency read port.
- Accepts shot-result writes from the game FSM over a ready/req/ack handshake. Writes are committed only during vertical blanking, so no frame shows a partial update.
- Provides a board-clear sweep and per-board hit counters for win detection.

Parameters:
GRID_N, 10, cells per board edge
CELLS, 100, cells per board (GRID_N*GRID_N)
SHIP_CELLS, 17, total ship cells per board; reaching this count asserts all_sunk

Ports:
clk  in  1  system clock (same domain as vga_if)
rst  in  1  synchronous reset, active-low
vblnk  in  1  vertical blanking from the timing chain
rd_addr_host  in  7  renderer cell index, host board (0..99)
rd_addr_guest  in  7  renderer cell index, guest board (0..99)
rd_state_host  out  2  cell state for rd_addr_host, 1 cycle later
rd_state_guest  out  2  cell state for rd_addr_guest, 1 cycle later
shot_ready  out  1  controller can accept a shot
shot_req  in  1  shot request, qualified by shot_ready
shot_board  in  1  0 = host board, 1 = guest board
shot_addr  in  7  target cell index
shot_hit  in  1  1 = hit, 0 = miss
shot_ack  out  1  1-cycle pulse: shot processed
shot_err  out  1  valid with shot_ack: rejected (index >= 100 or cell already shot)
clear_req  in  1  1-cycle pulse: clear both boards
clear_done  out  1  1-cycle pulse when sweep completes
hits_host  out  5  hit count, host board
hits_guest  out  5  hit count, guest board
all_sunk_host  out  1  hits_host == SHIP_CELLS
all_sunk_guest  out  1  hits_guest == SHIP_CELLS

Behaviour:
- Cell encoding is cell_t: 2'b00 UNKNOWN, 2'b01 MISS, 2'b10 HIT, 2'b11 reserved (never written). Storage is 2 x 100 x 2-bit flops.
- Reset (rst == 0 at a clk edge):
  - all cells UNKNOWN; counters 0; all outputs 0 except shot_ready = 1 in the cycle after reset releases;
  - state IDLE; clear_pending = 0.
- Read port:
  - rd_state_* is registered, latency 1 cycle, and is always served regardless of FSM state;
  - an index >= 100 returns UNKNOWN;
  - a write committed at edge N is visible on a read sampled at edge N.
- Handshake:
  - shot_ready = (state == IDLE) & !clear_pending;
  - a shot is accepted when shot_req & shot_ready; board, addr and hit are latched at acceptance;
  - shot_req while not ready is ignored; the requester must hold it until accepted.
- FSM states: IDLE, WAIT_VB, COMMIT, CLEAR.
  - IDLE:
    - if clear_pending -> CLEAR (clear has priority over a simultaneous shot_req);
    - else on accept -> WAIT_VB.
  - WAIT_VB: stay until vblnk == 1, then -> COMMIT. If vblnk is already high at acceptance, COMMIT follows on the next cycle.
  - COMMIT (one cycle):
    - if addr >= 100, or the latched cell != UNKNOWN: shot_ack = 1, shot_err = 1, no write;
    - else: write HIT or MISS, shot_ack = 1, shot_err = 0, and increment the board counter on HIT;
    - -> IDLE.
  - CLEAR:
    - a 7-bit index counts 0..99, writing UNKNOWN to the same index on both boards each cycle (100 cycles total);
    - at index 99: counters are zeroed, clear_done pulses, clear_pending drops, -> IDLE;
    - CLEAR is not gated on vblnk.
- clear_req arriving in any state sets clear_pending. Pulses arriving during CLEAR are absorbed; no second sweep runs.
- A shot that is already accepted completes (WAIT_VB, COMMIT, ack) before the clear starts.
- Counters saturate at 31 and never wrap. all_sunk_* is combinational from the registered counters.
- rst asserted mid-operation aborts any sweep or pending shot, with no ack and no clear_done.

Decomposition:
- Package battleship_pkg (shared with the game FSM): cell_t enum, GRID_N, CELLS, SHIP_CELLS, IDX_W = 7.
- One natural sub-module: hit_board (a single 100 x 2-bit store with one registered read port, one write port and a hit counter), instantiated twice.
- The controller FSM, handshake and clear sweep stay in hit_map_ctrl.

Test Plan:
1. Reset, then read every index 0..99 on both boards -> rd_state = 00 one cycle after each address; shot_ready = 1.
2. Shot guest addr 23, hit = 1, vblnk low for 50 cycles then high -> no ack while vblnk low; shot_ack at the first COMMIT after vblnk rises; rd_state_guest(23) = 10; hits_guest = 1.
3. Repeat the shot on guest 23 -> shot_ack & shot_err, cell unchanged, hits_guest stays 1. Shot on addr 100 -> ack + err, no write.
4. clear_req in the same cycle as shot_req from IDLE -> shot not accepted; sweep runs; clear_done exactly 100 cycles after CLEAR entry; all cells 00; counters 0.
5. 17 distinct host hits -> all_sunk_host rises on the 17th commit. Then 15 more hits -> counter saturates at 31.
6. rst low mid-sweep at index 40 -> next cycle: all cells UNKNOWN, state IDLE, no clear_done.

Source files
------------

// File: rtl/battleship_pkg.sv
// battleship_pkg -- definitions shared by the hit map controller and the game FSM.
//   cell_t     : per-cell shot state as stored and as shown to the renderer
//   GRID_N     : cells per board edge
//   CELLS      : cells per board
//   SHIP_CELLS : ship cells per board; a hit count equal to this means all ships are sunk
//   IDX_W      : width of a linear cell index (0..CELLS-1, with headroom for bad indices)
//   HITS_W     : width of the per-board hit counter
package battleship_pkg;

  localparam int GRID_N     = 10;
  localparam int CELLS      = GRID_N * GRID_N;
  localparam int SHIP_CELLS = 17;
  localparam int IDX_W      = 7;
  localparam int HITS_W     = 5;

  localparam logic [HITS_W-1:0] HITS_MAX = '1;

  typedef enum logic [1:0] {
    CELL_UNKNOWN = 2'b00,
    CELL_MISS    = 2'b01,
    CELL_HIT     = 2'b10,
    CELL_RSVD    = 2'b11   // never written
  } cell_t;

  // True when idx addresses a real cell on a board.
  function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
    return idx < IDX_W'(CELLS);
  endfunction

endpackage

// File: rtl/hit_board.sv
// hit_board -- one board's hit/miss store with a saturating hit counter.
//   clk, rst   : clock and synchronous active-low reset (clears all cells and the counter)
//   rd_addr    : renderer cell index; rd_state returns its state one cycle later
//                (UNKNOWN for an index past the board). A write on the same edge
//                to the same index is forwarded, so the read sees the new value.
//   wr_en      : write wr_state into cell wr_addr (ignored for an index past the board)
//   cur_state  : current stored state of cell wr_addr, used to reject repeat shots
//   hit_inc    : increment the hit counter (saturates at its maximum)
//   hit_clr    : zero the hit counter (takes priority over hit_inc)
//   hits       : registered hit count
module hit_board
  import battleship_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [1:0]        rd_state,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [1:0]        wr_state,
  output logic [1:0]        cur_state,
  input  logic              hit_inc,
  input  logic              hit_clr,
  output logic [HITS_W-1:0] hits
);

  cell_t             cell_reg [CELLS];
  cell_t             rd_state_reg;
  logic [HITS_W-1:0] hits_reg;
  logic              wr_ok;

  assign wr_ok = wr_en & idx_valid(wr_addr);

  // Cell storage is flops so the whole board clears in one reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CELLS; i++) begin
        cell_reg[i] <= CELL_UNKNOWN;
      end
    end else if (wr_ok) begin
      cell_reg[wr_addr] <= cell_t'(wr_state);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_state_reg <= CELL_UNKNOWN;
    end else if (!idx_valid(rd_addr)) begin
      rd_state_reg <= CELL_UNKNOWN;
    end else if (wr_ok && (wr_addr == rd_addr)) begin
      rd_state_reg <= cell_t'(wr_state);
    end else begin
      rd_state_reg <= cell_reg[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hits_reg <= '0;
    end else if (hit_clr) begin
      hits_reg <= '0;
    end else if (hit_inc && (hits_reg != HITS_MAX)) begin
      hits_reg <= hits_reg + 1'b1;
    end
  end

  assign cur_state = idx_valid(wr_addr) ? cell_reg[wr_addr] : CELL_UNKNOWN;
  assign rd_state  = rd_state_reg;
  assign hits      = hits_reg;

endmodule

// File: rtl/hit_map_ctrl.sv
// hit_map_ctrl -- owns the host and guest hit maps and schedules every access.
//   clk, rst            : system clock, synchronous active-low reset
//   vblnk               : vertical blanking; shot results are committed only while high
//   rd_addr_host/guest  : renderer cell indices; rd_state_host/guest one cycle later
//   shot_ready/req      : shot handshake; board/addr/hit latched when req & ready
//   shot_board/addr/hit : target board (0 host, 1 guest), cell index, hit flag
//   shot_ack, shot_err  : one-cycle completion pulse; err = bad index or cell already shot
//   clear_req/done      : request a sweep of both boards / pulse when the sweep finished
//   hits_host/guest     : saturating hit counters
//   all_sunk_host/guest : hit counter equals the number of ship cells
module hit_map_ctrl
  import battleship_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             vblnk,
  input  logic [IDX_W-1:0] rd_addr_host,
  input  logic [IDX_W-1:0] rd_addr_guest,
  output logic [1:0]       rd_state_host,
  output logic [1:0]       rd_state_guest,
  output logic             shot_ready,
  input  logic             shot_req,
  input  logic             shot_board,
  input  logic [IDX_W-1:0] shot_addr,
  input  logic             shot_hit,
  output logic             shot_ack,
  output logic             shot_err,
  input  logic             clear_req,
  output logic             clear_done,
  output logic [4:0]       hits_host,
  output logic [4:0]       hits_guest,
  output logic             all_sunk_host,
  output logic             all_sunk_guest
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VB,
    ST_COMMIT,
    ST_CLEAR
  } state_t;

  state_t           state_reg, state_next;
  logic             clear_pending_reg, clear_pending_next;
  logic [IDX_W-1:0] clr_idx_reg, clr_idx_next;
  logic             shot_board_reg;
  logic [IDX_W-1:0] shot_addr_reg;
  logic             shot_hit_reg;
  logic             clear_done_reg;

  logic             accept;
  logic             clr_last;
  logic             shot_bad;
  logic [IDX_W-1:0] wr_addr;
  logic [1:0]       wr_state;

  // Index 0 is the host board, index 1 the guest board.
  logic [1:0][IDX_W-1:0]  rd_addr_vec;
  logic [1:0][1:0]        rd_state_vec;
  logic [1:0][1:0]        cur_state_vec;
  logic [1:0]             wr_en_vec;
  logic [1:0]             hit_inc_vec;
  logic [1:0][HITS_W-1:0] hits_vec;

  assign rd_addr_vec[0] = rd_addr_host;
  assign rd_addr_vec[1] = rd_addr_guest;

  assign shot_ready = (state_reg == ST_IDLE) & ~clear_pending_reg;
  // A clear arriving together with a shot wins; the shot stays unaccepted.
  assign accept     = shot_req & shot_ready & ~clear_req;
  assign clr_last   = (state_reg == ST_CLEAR) && (clr_idx_reg == IDX_W'(CELLS - 1));
  assign shot_bad   = ~idx_valid(shot_addr_reg) | (cur_state_vec[shot_board_reg] != CELL_UNKNOWN);

  // Both boards share one write address/data path: sweep index during a clear,
  // latched shot otherwise.
  assign wr_addr  = (state_reg == ST_CLEAR) ? clr_idx_reg : shot_addr_reg;
  assign wr_state = (state_reg == ST_CLEAR) ? CELL_UNKNOWN
                  : (shot_hit_reg ? CELL_HIT : CELL_MISS);

  for (genvar gi = 0; gi < 2; gi++) begin : g_board
    logic commit_here;

    assign commit_here     = (state_reg == ST_COMMIT) & (shot_board_reg == 1'(gi)) & ~shot_bad;
    assign wr_en_vec[gi]   = (state_reg == ST_CLEAR) | commit_here;
    assign hit_inc_vec[gi] = commit_here & shot_hit_reg;

    hit_board u_board (
      .clk       (clk),
      .rst       (rst),
      .rd_addr   (rd_addr_vec[gi]),
      .rd_state  (rd_state_vec[gi]),
      .wr_en     (wr_en_vec[gi]),
      .wr_addr   (wr_addr),
      .wr_state  (wr_state),
      .cur_state (cur_state_vec[gi]),
      .hit_inc   (hit_inc_vec[gi]),
      .hit_clr   (clr_last),
      .hits      (hits_vec[gi])
    );
  end

  always_comb begin
    state_next = state_reg;
    shot_ack   = 1'b0;
    shot_err   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (clear_pending_reg) begin
          state_next = ST_CLEAR;
        end else if (accept) begin
          state_next = ST_WAIT_VB;
        end
      end
      ST_WAIT_VB: begin
        if (vblnk) begin
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        shot_ack   = 1'b1;
        shot_err   = shot_bad;
        state_next = ST_IDLE;
      end
      ST_CLEAR: begin
        if (clr_last) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    clear_pending_next = clear_pending_reg;
    clr_idx_next       = '0;
    if (clr_last) begin
      clear_pending_next = 1'b0;
    end else if (state_reg != ST_CLEAR) begin
      // Requests during a running sweep are absorbed by that sweep.
      clear_pending_next = clear_pending_reg | clear_req;
    end
    if ((state_reg == ST_CLEAR) && !clr_last) begin
      clr_idx_next = clr_idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg         <= ST_IDLE;
      clear_pending_reg <= 1'b0;
      clr_idx_reg       <= '0;
      shot_board_reg    <= 1'b0;
      shot_addr_reg     <= '0;
      shot_hit_reg      <= 1'b0;
      clear_done_reg    <= 1'b0;
    end else begin
      state_reg         <= state_next;
      clear_pending_reg <= clear_pending_next;
      clr_idx_reg       <= clr_idx_next;
      clear_done_reg    <= clr_last;
      if (accept) begin
        shot_board_reg <= shot_board;
        shot_addr_reg  <= shot_addr;
        shot_hit_reg   <= shot_hit;
      end
    end
  end

  assign clear_done     = clear_done_reg;
  assign rd_state_host  = rd_state_vec[0];
  assign rd_state_guest = rd_state_vec[1];
  assign hits_host      = hits_vec[0];
  assign hits_guest     = hits_vec[1];
  assign all_sunk_host  = (hits_vec[0] == HITS_W'(SHIP_CELLS));
  assign all_sunk_guest = (hits_vec[1] == HITS_W'(SHIP_CELLS));

endmodule

// File: tb/tb_hit_map_ctrl.sv
// tb_hit_map_ctrl -- self-checking bench for hit_map_ctrl: a directed vector table,
// random shots against a board/counter model, and hand-written clear/reset sequences.
module tb_hit_map_ctrl;

  localparam int NCELL = 100;
  localparam int SHIP  = 17;
  localparam int HMAX  = 31;

  logic       clk = 1'b0;
  logic       rst;
  logic       vblnk;
  logic [6:0] rd_addr_host, rd_addr_guest;
  logic [1:0] rd_state_host, rd_state_guest;
  logic       shot_ready, shot_req, shot_board, shot_hit, shot_ack, shot_err;
  logic [6:0] shot_addr;
  logic       clear_req, clear_done;
  logic [4:0] hits_host, hits_guest;
  logic       all_sunk_host, all_sunk_guest;

  int checks   = 0;
  int failures = 0;

  // Model: cell values 0 unknown, 1 miss, 2 hit; saturating hit counters.
  int cells [2][NCELL];
  int hits  [2];

  typedef struct {
    int board;
    int addr;
    int hit;
    int vb_low;
    int exp_err;
    int exp_state;
    int exp_hits;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  hit_map_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .vblnk          (vblnk),
    .rd_addr_host   (rd_addr_host),
    .rd_addr_guest  (rd_addr_guest),
    .rd_state_host  (rd_state_host),
    .rd_state_guest (rd_state_guest),
    .shot_ready     (shot_ready),
    .shot_req       (shot_req),
    .shot_board     (shot_board),
    .shot_addr      (shot_addr),
    .shot_hit       (shot_hit),
    .shot_ack       (shot_ack),
    .shot_err       (shot_err),
    .clear_req      (clear_req),
    .clear_done     (clear_done),
    .hits_host      (hits_host),
    .hits_guest     (hits_guest),
    .all_sunk_host  (all_sunk_host),
    .all_sunk_guest (all_sunk_guest)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int b = 0; b < 2; b++) begin
      hits[b] = 0;
      for (int a = 0; a < NCELL; a++) cells[b][a] = 0;
    end
  endfunction

  // Applies a shot to the model; returns the expected error flag.
  function automatic int model_shot(input int b, input int a, input int h);
    if (a >= NCELL) return 1;
    if (cells[b][a] != 0) return 1;
    cells[b][a] = h ? 2 : 1;
    if (h != 0 && hits[b] < HMAX) hits[b]++;
    return 0;
  endfunction

  function automatic int exp_cell(input int b, input int a);
    return (a >= NCELL) ? 0 : cells[b][a];
  endfunction

  // Issues one shot, holds vblnk low for vb_low cycles after acceptance (high at
  // acceptance when vb_low is 0), then raises it. Returns after the commit edge
  // with both read ports pointed at the target so the read shows the committed value.
  task automatic do_shot(input int b, input int a, input int h, input int vb_low,
                         output int early, output int ack, output int err);
    int n;
    n = 0;
    while (!shot_ready && n < 400) begin
      tick();
      n++;
    end
    check("shot_ready_wait", shot_ready, 1);
    shot_req      = 1'b1;
    shot_board    = 1'(b);
    shot_addr     = 7'(a);
    shot_hit      = 1'(h);
    vblnk         = (vb_low == 0);
    rd_addr_host  = 7'(a);
    rd_addr_guest = 7'(a);
    tick();
    shot_req = 1'b0;
    early    = 0;
    for (int i = 0; i < vb_low; i++) begin
      if (shot_ack) early = 1;
      tick();
    end
    if (shot_ack) early = 1;
    vblnk = 1'b1;
    tick();
    ack = shot_ack;
    err = shot_err;
    tick();
    vblnk = 1'b0;
    $display("shot board=%0d addr=%0d hit=%0d vb_low=%0d ack=%0d err=%0d hits=%0d/%0d",
             b, a, h, vb_low, ack, err, hits_host, hits_guest);
  endtask

  task automatic shot_checked(input string tag, input int b, input int a, input int h, input int vb_low);
    int early, ack, err, e;
    do_shot(b, a, h, vb_low, early, ack, err);
    e = model_shot(b, a, h);
    check({tag, "_ack_early"}, early, 0);
    check({tag, "_ack"}, ack, 1);
    check({tag, "_err"}, err, e);
    check({tag, "_cell"}, (b != 0) ? rd_state_guest : rd_state_host, exp_cell(b, a));
    check({tag, "_hits_host"}, hits_host, hits[0]);
    check({tag, "_hits_guest"}, hits_guest, hits[1]);
    check({tag, "_sunk_host"}, all_sunk_host, int'(hits[0] == SHIP));
    check({tag, "_sunk_guest"}, all_sunk_guest, int'(hits[1] == SHIP));
  endtask

  // Reads every cell of both boards (plus a few bad indices) against the model.
  // The guest port walks a different order so swapped ports are visible.
  task automatic check_all_cells(input string tag);
    int ga;
    for (int a = 0; a < NCELL + 4; a++) begin
      ga            = (a < NCELL) ? (a * 7) % NCELL : a;
      rd_addr_host  = 7'(a);
      rd_addr_guest = 7'(ga);
      tick();
      check({tag, "_rd_host"}, rd_state_host, exp_cell(0, a));
      check({tag, "_rd_guest"}, rd_state_guest, exp_cell(1, ga));
    end
  endtask

  initial begin
    int n, ack_cnt, done_cnt, early, ack, err;

    vecs[0] = '{1, 23, 1, 50, 0, 2, 1};
    vecs[1] = '{1, 23, 1, 2, 1, 2, 1};
    vecs[2] = '{1, 100, 0, 0, 1, 0, 1};
    vecs[3] = '{0, 5, 0, 3, 0, 1, 0};
    vecs[4] = '{1, 23, 0, 1, 1, 2, 1};
    vecs[5] = '{0, 99, 1, 0, 0, 2, 1};
    vecs[6] = '{0, 127, 1, 0, 1, 0, 1};
    vecs[7] = '{0, 5, 1, 0, 1, 1, 1};
    vecs[8] = '{1, 0, 0, 1, 0, 1, 1};

    rst = 1'b0; vblnk = 1'b0; shot_req = 1'b0; shot_board = 1'b0;
    shot_addr = '0; shot_hit = 1'b0; clear_req = 1'b0;
    rd_addr_host = '0; rd_addr_guest = '0;
    model_clear();

    // Reset state and empty boards.
    repeat (3) tick();
    rst = 1'b1;
    check("rst_shot_ready", shot_ready, 1);
    check("rst_shot_ack", shot_ack, 0);
    check("rst_shot_err", shot_err, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_hits_host", hits_host, 0);
    check("rst_hits_guest", hits_guest, 0);
    check("rst_sunk", {all_sunk_host, all_sunk_guest}, 0);
    check_all_cells("reset");

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      do_shot(vecs[i].board, vecs[i].addr, vecs[i].hit, vecs[i].vb_low, early, ack, err);
      void'(model_shot(vecs[i].board, vecs[i].addr, vecs[i].hit));
      check("tbl_ack_early", early, 0);
      check("tbl_ack", ack, 1);
      check("tbl_err", err, vecs[i].exp_err);
      check("tbl_cell", (vecs[i].board != 0) ? rd_state_guest : rd_state_host, vecs[i].exp_state);
      check("tbl_hits", (vecs[i].board != 0) ? hits_guest : hits_host, vecs[i].exp_hits);
    end

    // Random shots against the model.
    for (int i = 0; i < 80; i++) begin
      shot_checked("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, 104)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end
    check_all_cells("after_rand");

    // Clear together with a shot: the shot is refused and the sweep runs once,
    // finishing 100 cycles after it starts (101 edges after the request edge).
    vblnk = 1'b1;
    shot_req = 1'b1; shot_board = 1'b0; shot_addr = 7'd50; shot_hit = 1'b1;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    shot_req  = 1'b0;
    check("clr_ready_low", shot_ready, 0);
    n = 0;
    ack_cnt = 0;
    while (!clear_done && n < 300) begin
      clear_req = (n == 30);
      tick();
      n++;
      if (shot_ack) ack_cnt++;
    end
    clear_req = 1'b0;
    check("clr_done_latency", n, 101);
    check("clr_no_shot_ack", ack_cnt, 0);
    check("clr_hits_host", hits_host, 0);
    check("clr_hits_guest", hits_guest, 0);
    tick();
    check("clr_done_pulse", clear_done, 0);
    check("clr_ready_after", shot_ready, 1);
    done_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (clear_done) done_cnt++;
    end
    check("clr_single_sweep", done_cnt, 0);
    vblnk = 1'b0;
    model_clear();
    check_all_cells("after_clear");

    // 17 host hits reach all_sunk, then the counter saturates at 31.
    for (int i = 0; i < 32; i++) begin
      shot_checked("sat", 0, i, 1, 0);
    end
    check("sat_hits_host", hits_host, 31);
    for (int i = 90; i < 96; i++) begin
      shot_checked("guest_hi", 1, i, 1, 0);
    end

    // Reset at sweep index 40 aborts the sweep and wipes both boards at once.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (41) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_clear_done", clear_done, 0);
    check("abort_shot_ready", shot_ready, 1);
    check("abort_hits_host", hits_host, 0);
    check("abort_hits_guest", hits_guest, 0);
    model_clear();
    done_cnt = 0;
    ack_cnt  = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (clear_done) done_cnt++;
      if (shot_ack) ack_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_no_ack", ack_cnt, 0);
    check_all_cells("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
